rr_arb138: RTL and testbench



---
 rtl/rr_arb138_pkg.sv | 14 +
 rtl/dec3to8_n.sv | 17 +
 rtl/rr_arb138.sv | 135 +++++++++++++
 tb/tb_rr_arb138.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb138_pkg.sv
// Shared constants and FSM state encoding for the rr_arb138 round-robin arbiter.
package rr_arb138_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [N_REQ-1:0] GRANT_NONE = 8'hFF;

  // FSM state encoding, kept as plain constants for legacy tool flows
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t GAP   = 2'd2;

endpackage

// File: rtl/dec3to8_n.sv
// 3-to-8 active-low decoder with active-high enable (G1 role).
// With g1 low every output line is high; otherwise only line a is driven low.
module dec3to8_n (
  input  logic [2:0] a,
  input  logic       g1,
  output logic [7:0] y
);

  // Decode the select into a single low line when enabled
  always_comb begin
    y = 8'hFF;
    if (g1) begin
      y[a] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb138.sv
// Round-robin arbiter for 8 requesters with active-low one-hot grants.
// A one-cycle all-high gap always separates two grants (break-before-make).
// Optional hold limit enabled by defining ARB_TIMEOUT_EN: a grant that lasts
// MAX_HOLD cycles is revoked and timeout pulses for one cycle.
module rr_arb138 #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [N_REQ-1:0]                req,
  output logic [N_REQ-1:0]                grant_n,
  output logic [rr_arb138_pkg::IDX_W-1:0] grant_idx,
  output logic                            grant_valid,
  output logic                            timeout
);

  import rr_arb138_pkg::*;

  // The grant lines come straight from a 3-bit decoder, so only 8 is legal
  if (N_REQ != rr_arb138_pkg::N_REQ) begin : g_bad_n_req
    $error("rr_arb138: N_REQ must be 8");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arb138: MAX_HOLD must be >= 2");
  end

  // Next requester after 'last' in circular order with an active request
  function automatic logic [IDX_W-1:0] pick_winner(input logic [IDX_W-1:0] last,
                                                   input logic [N_REQ-1:0] r);
    logic [IDX_W-1:0] idx;
    logic             found;
    pick_winner = last;
    found       = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + IDX_W'(k);
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] winner;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              to_q, to_d;
`endif

  assign winner = pick_winner(last_q, req);

  // Next-state logic: arbitrate from IDLE/GAP, hold or release in GRANT
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      GRANT: begin
        // Enable loss wins over both release and the hold limit
        if (!en) begin
          state_d = IDLE;
        end else if (!req[idx_q]) begin
          state_d = GAP;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d = GAP;
          to_d    = 1'b1;
        end else begin
          hold_d  = hold_q + 1'b1;
`endif
        end
      end
      default: begin
        if (en && (req != '0)) begin
          state_d = GRANT;
          idx_d   = winner;
          last_d  = winner;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      idx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  // en gates the grant combinationally so dropping it blanks the lines at once
  assign grant_valid = (state_q == GRANT) & en;
  assign grant_idx   = idx_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  dec3to8_n u_dec (
    .a  (idx_q),
    .g1 (grant_valid),
    .y  (grant_n)
  );

endmodule

// File: tb/tb_rr_arb138.sv
// Self-checking bench for rr_arb138: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the arbiter.
module tb_rr_arb138;

  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant_n;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who holds the resource (-1 = nobody), last winner, cycles held
  int m_holder;
  int m_last;
  int m_held;
  bit m_to;

  always #5 clk = ~clk;

  rr_arb138 #(
    .N_REQ    (8),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant_n     (grant_n),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  function automatic void model_reset();
    m_holder = -1;
    m_last   = 7;
    m_held   = 0;
    m_to     = 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge
  function automatic void model_edge();
    bit found;
    m_to = 1'b0;
    if (m_holder >= 0) begin
      if (!en) begin
        m_holder = -1;
      end else if (!req[m_holder]) begin
        m_holder = -1;
      end else if (TIMEOUT_ON && m_held == MAX_HOLD) begin
        m_holder = -1;
        m_to     = 1'b1;
      end else begin
        m_held++;
      end
    end else if (en && req != 8'h00) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(m_last + k) % 8]) begin
          m_holder = (m_last + k) % 8;
          found    = 1'b1;
        end
      end
      m_last = m_holder;
      m_held = 1;
    end
  endfunction

  // Advance one clock and compare every output with the model
  task automatic step();
    logic [7:0] exp_n;
    logic       exp_v;
    @(posedge clk);
    model_edge();
    #1;
    exp_v = (m_holder >= 0) && en;
    exp_n = exp_v ? ~(8'd1 << m_holder) : 8'hFF;
    vectors++;
    if (grant_n !== exp_n) begin
      miscompares++;
      $display("FAIL model_grant_n: got %h expected %h (req=%h en=%b)", grant_n, exp_n, req, en);
    end
    vectors++;
    if (grant_valid !== exp_v) begin
      miscompares++;
      $display("FAIL model_grant_valid: got %b expected %b", grant_valid, exp_v);
    end
    vectors++;
    if (timeout !== m_to) begin
      miscompares++;
      $display("FAIL model_timeout: got %b expected %b", timeout, m_to);
    end
    if (exp_v) begin
      vectors++;
      if (grant_idx !== 3'(m_holder)) begin
        miscompares++;
        $display("FAIL model_grant_idx: got %0d expected %0d", grant_idx, m_holder);
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (grant_n !== 8'hFF || grant_valid !== 1'b0 || timeout !== 1'b0 || grant_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got n=%h v=%b to=%b idx=%0d expected n=ff v=0 to=0 idx=0",
               grant_n, grant_valid, timeout, grant_idx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en  = 1'b1;
    req = 8'h00;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (grant_n !== 8'hFF || grant_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_req: got n=%h v=%b expected n=ff v=0", grant_n, grant_valid);
      end
    end
  endtask

  task automatic test_basic();
    en  = 1'b1;
    req = 8'h81;
    apply_reset();
    step();
    vectors++;
    if (grant_n !== 8'hFE || grant_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL first_grant: got n=%h idx=%0d expected n=fe idx=0", grant_n, grant_idx);
    end
    req = 8'h80;
    step();
    vectors++;
    if (grant_n !== 8'hFF) begin
      miscompares++;
      $display("FAIL release_gap: got %h expected ff", grant_n);
    end
    step();
    vectors++;
    if (grant_n !== 8'h7F || grant_idx !== 3'd7) begin
      miscompares++;
      $display("FAIL second_grant: got n=%h idx=%0d expected n=7f idx=7", grant_n, grant_idx);
    end
  endtask

  task automatic test_rotate();
    en  = 1'b1;
    req = 8'hFF;
    apply_reset();
    for (int g = 0; g < 9; g++) begin
      step();
      vectors++;
      if (grant_idx !== 3'(g % 8) || grant_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rotate_order: got idx=%0d v=%b expected idx=%0d v=1",
                 grant_idx, grant_valid, g % 8);
      end
      step();
      step();
      req[g % 8] = 1'b0;
      step();
      vectors++;
      if (grant_n !== 8'hFF) begin
        miscompares++;
        $display("FAIL rotate_gap: got %h expected ff", grant_n);
      end
      req = 8'hFF;
    end
  endtask

  task automatic test_enable();
    en  = 1'b1;
    req = 8'h20;
    apply_reset();
    step();
    vectors++;
    if (grant_n !== 8'hDF || grant_idx !== 3'd5) begin
      miscompares++;
      $display("FAIL en_pre_grant: got n=%h idx=%0d expected n=df idx=5", grant_n, grant_idx);
    end
    en = 1'b0;
    #1;
    vectors++;
    if (grant_n !== 8'hFF || grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_blank_same_cycle: got n=%h v=%b expected n=ff v=0", grant_n, grant_valid);
    end
    step();
    en = 1'b1;
    #1;
    vectors++;
    if (grant_n !== 8'hFF) begin
      miscompares++;
      $display("FAIL en_idle_after_drop: got %h expected ff", grant_n);
    end
    step();
    vectors++;
    if (grant_n !== 8'hDF || grant_idx !== 3'd5) begin
      miscompares++;
      $display("FAIL en_regrant: got n=%h idx=%0d expected n=df idx=5", grant_n, grant_idx);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    en  = 1'b1;
    req = 8'h0C;
    apply_reset();
    for (int i = 0; i < MAX_HOLD; i++) begin
      step();
      vectors++;
      if (grant_n !== 8'hFB || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold: got n=%h to=%b expected n=fb to=0", grant_n, timeout);
      end
    end
    step();
    vectors++;
    if (grant_n !== 8'hFF || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_revoke: got n=%h to=%b expected n=ff to=1", grant_n, timeout);
    end
    step();
    vectors++;
    if (grant_n !== 8'hF7 || grant_idx !== 3'd3 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_next: got n=%h idx=%0d to=%b expected n=f7 idx=3 to=0",
               grant_n, grant_idx, timeout);
    end
  endtask
`else
  task automatic test_hold_forever();
    en  = 1'b1;
    req = 8'h0C;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (grant_n !== 8'hFB || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_forever: got n=%h to=%b expected n=fb to=0", grant_n, timeout);
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    en  = 1'b1;
    req = 8'h08;
    apply_reset();
    step();
    vectors++;
    if (grant_n !== 8'hF7) begin
      miscompares++;
      $display("FAIL mid_reset_pre: got %h expected f7", grant_n);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (grant_n !== 8'hFF || grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got n=%h v=%b expected n=ff v=0", grant_n, grant_valid);
    end
    model_reset();
    req = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (grant_n !== 8'hFE || grant_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset_first: got n=%h idx=%0d expected n=fe idx=0", grant_n, grant_idx);
    end
  endtask

  task automatic test_random();
    en  = 1'b1;
    req = 8'h00;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req = 8'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      step();
      vectors++;
      if ($countones(~grant_n) > 1) begin
        miscompares++;
        $display("FAIL onehot_invariant: got %h expected at most one low bit", grant_n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;
    model_reset();
    test_reset();
    test_basic();
    test_rotate();
    test_enable();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
